control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Moore-style control unit that drives the Datapath control inputs (pc_out, mdr_out, mar_enable, z_enable, op_code, register in/out strobes, …) one micro-step per clock.
- Replaces hand-sequenced bench stimulus. Fetches via PC→MAR→MDR→IR, decodes the instruction register (IR) fed back from the Datapath, and sequences the ALU execute steps.
- Supports R-type ALU, immediate ALU, unary and mul/div instructions.

Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot reg_in/reg_out vectors
- OPW, 5, opcode width (IR[31:27])
- CW, 19, immediate field width (IR[18:0])

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- run  in  1  start/continue fetching; sampled only in IDLE
- ir  in  32  IR contents from Datapath; valid from T3 onward
- pc_out, mdr_out, zlo_out, zhi_out, c_out  out  1 each  bus drive strobes
- mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, pc_increment, read, lo_enable, hi_enable  out  1 each  load strobes
- reg_in  out  NUM_REGS  one-hot register load enable
- reg_out  out  NUM_REGS  one-hot register bus drive
- op_code  out  OPW  ALU function
- c_sign_ext  out  32  IR[18:0] sign-extended to 32 bits; continuous
- instr_done  out  1  one-cycle pulse in the last step of each instruction
- illegal  out  1  sticky; set on unsupported opcode

Behaviour:
- Fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. One state per clock.
- Outputs are a combinational decode of state and ir.
- Any output not listed as asserted in a state is 0. In IDLE and HALT all strobes are 0 and op_code=0.
- Reset:
  - clr=1 at a clock edge → state IDLE, illegal=0, all strobes 0.
  - clr overrides everything, including mid-instruction; no partial step completes after that edge.
- IDLE: run=1 → T0; else remain in IDLE.
- Fetch:
  - T0: pc_out, mar_enable, pc_increment.
  - T1: read, mdr_enable.
  - T2: mdr_out, ir_enable.
- Decode (at T3):
  - Legal opcodes: 00011..10010.
  - Opcodes 00000–00010 (ld/ldi/st) and >10010 → next state HALT, illegal←1. All strobes are 0 during that T3.
- R-type (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: reg_out[Rb], y_enable.
  - T4: reg_out[Rc], op_code=opcode, z_enable.
  - T5: zlo_out, reg_in[Ra], instr_done.
- Immediate (addi, andi, ori):
  - As R-type, except T4 drives c_out instead of reg_out[Rc].
  - op_code maps addi→00011, andi→00101, ori→00110.
- Unary (neg, not):
  - T3: reg_out[Rb], op_code=opcode, z_enable.
  - T4: zlo_out, reg_in[Ra], instr_done.
- mul, div:
  - T3: reg_out[Ra], y_enable.
  - T4: reg_out[Rb], op_code=opcode, z_enable.
  - T5: zlo_out, lo_enable.
  - T6: zhi_out, hi_enable, instr_done.
- After the instr_done step: run=1 → T0 (back-to-back, no bubble); else → IDLE.
- run is ignored mid-instruction; a started instruction always completes.
- HALT is absorbing; only clr exits it.
- Latency: R-type/immediate 6 clocks, unary 5, mul/div 7.
- Ra==Rb or other register-field aliasing needs no special handling; each step drives exactly one one-hot bit per vector.
- reg_in and reg_out are never both nonzero in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (ld_opcode … not_opcode, 5-bit)
  - state encoding (4-bit)
  - IR field bit positions
- The datapath and benches use the same package.
- Sub-module reg_select_decoder: 4-bit field → NUM_REGS one-hot with enable. It is instantiated twice, for reg_in and reg_out.

Test Plan:
- Reset then run=1, ir=0x1A1B8000 (ADD R4,R3,R7):
  - T3: reg_out=0x0008, y_enable.
  - T4: reg_out=0x0080, op_code=00011, z_enable.
  - T5: reg_in=0x0010, zlo_out, instr_done.
  - Then next state IDLE with run=0.
- ir=0x610FFFFB (ADDI R2,R1,-5):
  - c_sign_ext=0xFFFFFFFB.
  - T4: c_out=1, reg_out=0, op_code=00011.
  - T5: reg_in=0x0004.
- ir=0x82B00000 (MUL R5,R6): T3 reg_out=0x0020; T4 reg_out=0x0040 with op_code=10000; T5 lo_enable; T6 hi_enable with instr_done; total 7 clocks from T0.
- ir=0xA0000000 (opcode 10100):
  - After T3: state HALT, illegal=1, all strobes 0.
  - Holds with run=1 until clr; after clr, illegal=0.
- Back-to-back:
  - run held 1 across two ADDs.
  - T0 of the second immediately follows T5 of the first.
  - instr_done pulses exactly twice.
- clr=1 during T4 of ADD: next cycle IDLE, z_enable=0, reg_in=0; no T5 writeback occurs.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and IR field positions.
// Used by the control sequencer, the datapath and the benches.
package cpu_pkg;

    localparam int IR_OP_HI = 31;
    localparam int IR_OP_LO = 27;
    localparam int IR_RA_HI = 26;
    localparam int IR_RA_LO = 23;
    localparam int IR_RB_HI = 22;
    localparam int IR_RB_LO = 19;
    localparam int IR_RC_HI = 18;
    localparam int IR_RC_LO = 15;
    localparam int IR_C_HI  = 18;

    localparam logic [4:0] ld_opcode   = 5'b00000;
    localparam logic [4:0] ldi_opcode  = 5'b00001;
    localparam logic [4:0] st_opcode   = 5'b00010;
    localparam logic [4:0] add_opcode  = 5'b00011;
    localparam logic [4:0] sub_opcode  = 5'b00100;
    localparam logic [4:0] and_opcode  = 5'b00101;
    localparam logic [4:0] or_opcode   = 5'b00110;
    localparam logic [4:0] ror_opcode  = 5'b00111;
    localparam logic [4:0] rol_opcode  = 5'b01000;
    localparam logic [4:0] shr_opcode  = 5'b01001;
    localparam logic [4:0] shra_opcode = 5'b01010;
    localparam logic [4:0] shl_opcode  = 5'b01011;
    localparam logic [4:0] addi_opcode = 5'b01100;
    localparam logic [4:0] andi_opcode = 5'b01101;
    localparam logic [4:0] ori_opcode  = 5'b01110;
    localparam logic [4:0] div_opcode  = 5'b01111;
    localparam logic [4:0] mul_opcode  = 5'b10000;
    localparam logic [4:0] neg_opcode  = 5'b10001;
    localparam logic [4:0] not_opcode  = 5'b10010;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_ILLEGAL
    } instr_class_t;

    function automatic instr_class_t classify(input logic [4:0] op);
        if (op >= add_opcode && op <= shl_opcode)
            return CLS_RTYPE;
        else if (op >= addi_opcode && op <= ori_opcode)
            return CLS_IMM;
        else if (op == mul_opcode || op == div_opcode)
            return CLS_MULDIV;
        else if (op == neg_opcode || op == not_opcode)
            return CLS_UNARY;
        else
            return CLS_ILLEGAL;
    endfunction

    // Immediate forms reuse the ALU function of their register-register counterpart.
    function automatic logic [4:0] imm_alu_code(input logic [4:0] op);
        case (op)
            andi_opcode: return and_opcode;
            ori_opcode:  return or_opcode;
            default:     return add_opcode;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// Turns a 4-bit register field into a one-hot enable vector; all zero when disabled
// or when the field addresses a register that does not exist.
module reg_select_decoder #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (int'(sel) < NUM_REGS))
            onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetches PC->MAR->MDR->IR, decodes IR and steps the datapath
// through the ALU execute phases, one micro-step per clock.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPW      = 5,
    parameter int CW       = 19
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    output logic                pc_out,
    output logic                mdr_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                c_out,
    output logic                mar_enable,
    output logic                mdr_enable,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                pc_enable,
    output logic                pc_increment,
    output logic                read,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [OPW-1:0]      op_code,
    output logic [31:0]         c_sign_ext,
    output logic                instr_done,
    output logic                illegal,
    output state_t              state
);

    state_t       state_next;
    instr_class_t cls;
    logic [4:0]   opcode;
    logic [3:0]   ra, rb, rc;
    logic         in_en, out_en;
    logic [3:0]   in_sel, out_sel;

    assign opcode = ir[IR_OP_HI:IR_OP_LO];
    assign ra     = ir[IR_RA_HI:IR_RA_LO];
    assign rb     = ir[IR_RB_HI:IR_RB_LO];
    assign rc     = ir[IR_RC_HI:IR_RC_LO];
    assign cls    = classify(opcode);

    assign c_sign_ext = {{(32-CW){ir[CW-1]}}, ir[CW-1:0]};

    always_ff @(posedge clk) begin
        if (clr)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (clr)
            illegal <= 1'b0;
        else if (state == ST_T3 && cls == CLS_ILLEGAL)
            illegal <= 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = run ? ST_T0 : ST_IDLE;
            ST_T0:   state_next = ST_T1;
            ST_T1:   state_next = ST_T2;
            ST_T2:   state_next = ST_T3;
            ST_T3:   state_next = (cls == CLS_ILLEGAL) ? ST_HALT : ST_T4;
            ST_T4: begin
                if (cls == CLS_UNARY)
                    state_next = run ? ST_T0 : ST_IDLE;
                else
                    state_next = ST_T5;
            end
            ST_T5: begin
                if (cls == CLS_MULDIV)
                    state_next = ST_T6;
                else
                    state_next = run ? ST_T0 : ST_IDLE;
            end
            ST_T6:   state_next = run ? ST_T0 : ST_IDLE;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_out       = 1'b0;
        mdr_out      = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        c_out        = 1'b0;
        mar_enable   = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        read         = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        op_code      = '0;
        instr_done   = 1'b0;
        in_en        = 1'b0;
        in_sel       = '0;
        out_en       = 1'b0;
        out_sel      = '0;
        case (state)
            ST_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
            end
            ST_T1: begin
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            ST_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        out_en   = 1'b1;
                        out_sel  = rb;
                        y_enable = 1'b1;
                    end
                    CLS_UNARY: begin
                        out_en   = 1'b1;
                        out_sel  = rb;
                        op_code  = OPW'(opcode);
                        z_enable = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_en   = 1'b1;
                        out_sel  = ra;
                        y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_RTYPE: begin
                        out_en   = 1'b1;
                        out_sel  = rc;
                        op_code  = OPW'(opcode);
                        z_enable = 1'b1;
                    end
                    CLS_IMM: begin
                        c_out    = 1'b1;
                        op_code  = OPW'(imm_alu_code(opcode));
                        z_enable = 1'b1;
                    end
                    CLS_UNARY: begin
                        zlo_out    = 1'b1;
                        in_en      = 1'b1;
                        in_sel     = ra;
                        instr_done = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_en   = 1'b1;
                        out_sel  = rb;
                        op_code  = OPW'(opcode);
                        z_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                if (cls == CLS_MULDIV) begin
                    zlo_out   = 1'b1;
                    lo_enable = 1'b1;
                end else begin
                    zlo_out    = 1'b1;
                    in_en      = 1'b1;
                    in_sel     = ra;
                    instr_done = 1'b1;
                end
            end
            ST_T6: begin
                zhi_out    = 1'b1;
                hi_enable  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_in_dec (
        .sel    (in_sel),
        .en     (in_en),
        .onehot (reg_in)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_reg_out_dec (
        .sel    (out_sel),
        .en     (out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed per-cycle vector table, then randomized
// instruction streams checked against a queue-of-micro-steps reference model.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam logic [15:0] B_PC_OUT  = 16'h0001;
    localparam logic [15:0] B_MDR_OUT = 16'h0002;
    localparam logic [15:0] B_ZLO     = 16'h0004;
    localparam logic [15:0] B_ZHI     = 16'h0008;
    localparam logic [15:0] B_C_OUT   = 16'h0010;
    localparam logic [15:0] B_MAR     = 16'h0020;
    localparam logic [15:0] B_MDR_EN  = 16'h0040;
    localparam logic [15:0] B_IR_EN   = 16'h0080;
    localparam logic [15:0] B_Y       = 16'h0100;
    localparam logic [15:0] B_Z       = 16'h0200;
    localparam logic [15:0] B_PC_INC  = 16'h0800;
    localparam logic [15:0] B_READ    = 16'h1000;
    localparam logic [15:0] B_LO      = 16'h2000;
    localparam logic [15:0] B_HI      = 16'h4000;
    localparam logic [15:0] B_DONE    = 16'h8000;
    localparam logic [15:0] F0 = B_PC_OUT | B_MAR | B_PC_INC;
    localparam logic [15:0] F1 = B_READ | B_MDR_EN;
    localparam logic [15:0] F2 = B_MDR_OUT | B_IR_EN;

    localparam logic [31:0] I_ADD  = 32'h1A1B8000;
    localparam logic [31:0] I_ADDI = 32'h610FFFFB;
    localparam logic [31:0] I_MUL  = 32'h82B00000;
    localparam logic [31:0] I_BAD  = 32'hA0000000;

    typedef struct packed {
        logic [15:0] stb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
    } out_t;

    typedef struct {
        logic        clr;
        logic        run;
        logic [31:0] w;
        out_t        exp;
        logic        ill;
    } vec_t;

    typedef struct {
        out_t o;
        bit   halt_after;
    } step_t;

    logic        clk = 1'b0;
    logic        clr, run;
    logic [31:0] ir;
    logic        pc_out, mdr_out, zlo_out, zhi_out, c_out;
    logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable;
    logic        pc_increment, read, lo_enable, hi_enable;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  op_code;
    logic [31:0] c_sign_ext;
    logic        instr_done, illegal;
    state_t      dut_state;
    out_t        act;

    int checks = 0;
    int failures = 0;

    vec_t  vt[$];
    step_t mq[$];
    bit    m_halted, m_ill;

    always #5 clk = ~clk;

    control_sequencer #(.NUM_REGS(16), .OPW(5), .CW(19)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir),
        .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .c_out(c_out),
        .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
        .y_enable(y_enable), .z_enable(z_enable), .pc_enable(pc_enable),
        .pc_increment(pc_increment), .read(read), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .reg_in(reg_in), .reg_out(reg_out), .op_code(op_code), .c_sign_ext(c_sign_ext),
        .instr_done(instr_done), .illegal(illegal), .state(dut_state)
    );

    assign act = {instr_done, hi_enable, lo_enable, read, pc_increment, pc_enable, z_enable,
                  y_enable, ir_enable, mdr_enable, mar_enable, c_out, zhi_out, zlo_out,
                  mdr_out, pc_out, reg_in, reg_out, op_code};

    function automatic logic [31:0] sext19(input logic [31:0] w);
        logic signed [18:0] f;
        logic signed [31:0] v;
        f = w[18:0];
        v = f;
        return v;
    endfunction

    function automatic out_t mk(input logic [15:0] stb, rin, rout, input logic [4:0] op);
        out_t o;
        o.stb = stb; o.rin = rin; o.rout = rout; o.op = op;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t exp, input logic exp_ill);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got stb=%h in=%h out=%h op=%b, want stb=%h in=%h out=%h op=%b",
                     name, $time, act.stb, act.rin, act.rout, act.op, exp.stb, exp.rin, exp.rout, exp.op);
        end
        checks++;
        if (illegal !== exp_ill) begin
            failures++;
            $display("FAIL %s_illegal t=%0t: got %b want %b", name, $time, illegal, exp_ill);
        end
        checks++;
        if (c_sign_ext !== sext19(ir)) begin
            failures++;
            $display("FAIL %s_c_sign_ext t=%0t: got %h want %h", name, $time, c_sign_ext, sext19(ir));
        end
        checks++;
        if (reg_in != 16'h0 && reg_out != 16'h0) begin
            failures++;
            $display("FAIL %s_reg_exclusive t=%0t: reg_in=%h reg_out=%h want one of them zero",
                     name, $time, reg_in, reg_out);
        end
    endtask

    task automatic add(input logic c, input logic r, input logic [31:0] w, input logic [15:0] stb,
                       input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] op,
                       input logic ill);
        vec_t v;
        v.clr = c; v.run = r; v.w = w; v.exp = mk(stb, rin, rout, op); v.ill = ill;
        vt.push_back(v);
    endtask

    // Reference model: every instruction expands into the list of micro-steps it must show.
    task automatic push_step(input out_t o, input bit h);
        step_t s;
        s.o = o; s.halt_after = h;
        mq.push_back(s);
    endtask

    task automatic push_instr(input logic [31:0] w);
        int op;
        logic [15:0] ra1, rb1, rc1;
        logic [4:0] alu;
        op  = int'(w[31:27]);
        ra1 = 16'(1) << w[26:23];
        rb1 = 16'(1) << w[22:19];
        rc1 = 16'(1) << w[18:15];
        push_step(mk(F0, 0, 0, 0), 0);
        push_step(mk(F1, 0, 0, 0), 0);
        push_step(mk(F2, 0, 0, 0), 0);
        if (op < 3 || op > 18) begin
            push_step(mk(0, 0, 0, 0), 1);
        end else if (op <= 11) begin
            push_step(mk(B_Y, 0, rb1, 0), 0);
            push_step(mk(B_Z, 0, rc1, w[31:27]), 0);
            push_step(mk(B_ZLO | B_DONE, ra1, 0, 0), 0);
        end else if (op <= 14) begin
            alu = (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6;
            push_step(mk(B_Y, 0, rb1, 0), 0);
            push_step(mk(B_C_OUT | B_Z, 0, 0, alu), 0);
            push_step(mk(B_ZLO | B_DONE, ra1, 0, 0), 0);
        end else if (op <= 16) begin
            push_step(mk(B_Y, 0, ra1, 0), 0);
            push_step(mk(B_Z, 0, rb1, w[31:27]), 0);
            push_step(mk(B_ZLO | B_LO, 0, 0, 0), 0);
            push_step(mk(B_ZHI | B_HI | B_DONE, 0, 0, 0), 0);
        end else begin
            push_step(mk(B_Z, 0, rb1, w[31:27]), 0);
            push_step(mk(B_ZLO | B_DONE, ra1, 0, 0), 0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int v;
        logic [4:0] op;
        logic [31:0] r;
        if ($urandom_range(0, 9) != 0) begin
            op = 5'($urandom_range(3, 18));
        end else begin
            v  = $urandom_range(0, 15);
            op = (v < 3) ? 5'(v) : 5'(v + 16);
        end
        r = $urandom();
        return {op, r[26:0]};
    endfunction

    task automatic start_instr();
        logic [31:0] w;
        w = rand_instr();
        ir = w;
        push_instr(w);
    endtask

    initial begin
        int b2b_lo, b2b_hi, done_cnt;
        logic s_done;
        step_t s;
        out_t exp;

        clr = 1'b1; run = 1'b0; ir = 32'h0;
        repeat (2) @(posedge clk);

        add(1, 0, I_ADD, 0, 0, 0, 0, 0);
        // ADD R4,R3,R7 then idle
        add(0, 1, I_ADD, F0, 0, 0, 0, 0);
        add(0, 0, I_ADD, F1, 0, 0, 0, 0);
        add(0, 0, I_ADD, F2, 0, 0, 0, 0);
        add(0, 0, I_ADD, B_Y, 0, 16'h0008, 0, 0);
        add(0, 0, I_ADD, B_Z, 0, 16'h0080, 5'b00011, 0);
        add(0, 0, I_ADD, B_ZLO | B_DONE, 16'h0010, 0, 0, 0);
        add(0, 0, I_ADD, 0, 0, 0, 0, 0);
        // ADDI R2,R1,-5
        add(0, 1, I_ADDI, F0, 0, 0, 0, 0);
        add(0, 0, I_ADDI, F1, 0, 0, 0, 0);
        add(0, 0, I_ADDI, F2, 0, 0, 0, 0);
        add(0, 0, I_ADDI, B_Y, 0, 16'h0002, 0, 0);
        add(0, 0, I_ADDI, B_C_OUT | B_Z, 0, 0, 5'b00011, 0);
        add(0, 0, I_ADDI, B_ZLO | B_DONE, 16'h0004, 0, 0, 0);
        add(0, 0, I_ADDI, 0, 0, 0, 0, 0);
        // MUL R5,R6: seven clocks from T0
        add(0, 1, I_MUL, F0, 0, 0, 0, 0);
        add(0, 0, I_MUL, F1, 0, 0, 0, 0);
        add(0, 0, I_MUL, F2, 0, 0, 0, 0);
        add(0, 0, I_MUL, B_Y, 0, 16'h0020, 0, 0);
        add(0, 0, I_MUL, B_Z, 0, 16'h0040, 5'b10000, 0);
        add(0, 0, I_MUL, B_ZLO | B_LO, 0, 0, 0, 0);
        add(0, 0, I_MUL, B_ZHI | B_HI | B_DONE, 0, 0, 0, 0);
        add(0, 0, I_MUL, 0, 0, 0, 0, 0);
        // Unsupported opcode: halt, sticky illegal, only clr exits
        add(0, 1, I_BAD, F0, 0, 0, 0, 0);
        add(0, 1, I_BAD, F1, 0, 0, 0, 0);
        add(0, 1, I_BAD, F2, 0, 0, 0, 0);
        add(0, 1, I_BAD, 0, 0, 0, 0, 0);
        add(0, 1, I_BAD, 0, 0, 0, 0, 1);
        add(0, 1, I_BAD, 0, 0, 0, 0, 1);
        add(0, 1, I_BAD, 0, 0, 0, 0, 1);
        add(1, 0, I_BAD, 0, 0, 0, 0, 0);
        add(0, 0, I_ADD, 0, 0, 0, 0, 0);
        // Back-to-back ADDs with run held high
        b2b_lo = vt.size();
        for (int k = 0; k < 2; k++) begin
            add(0, 1, I_ADD, F0, 0, 0, 0, 0);
            add(0, 1, I_ADD, F1, 0, 0, 0, 0);
            add(0, 1, I_ADD, F2, 0, 0, 0, 0);
            add(0, 1, I_ADD, B_Y, 0, 16'h0008, 0, 0);
            add(0, 1, I_ADD, B_Z, 0, 16'h0080, 5'b00011, 0);
            add(0, 1, I_ADD, B_ZLO | B_DONE, 16'h0010, 0, 0, 0);
        end
        add(0, 0, I_ADD, 0, 0, 0, 0, 0);
        b2b_hi = vt.size();
        // clr during T4 aborts before writeback
        add(0, 1, I_ADD, F0, 0, 0, 0, 0);
        add(0, 1, I_ADD, F1, 0, 0, 0, 0);
        add(0, 1, I_ADD, F2, 0, 0, 0, 0);
        add(0, 1, I_ADD, B_Y, 0, 16'h0008, 0, 0);
        add(0, 1, I_ADD, B_Z, 0, 16'h0080, 5'b00011, 0);
        add(1, 0, I_ADD, 0, 0, 0, 0, 0);
        add(0, 0, I_ADD, 0, 0, 0, 0, 0);

        done_cnt = 0;
        for (int i = 0; i < vt.size(); i++) begin
            clr = vt[i].clr; run = vt[i].run; ir = vt[i].w;
            @(posedge clk); #2;
            check_out($sformatf("vec%0d", i), vt[i].exp, vt[i].ill);
            if (i >= b2b_lo && i < b2b_hi && instr_done === 1'b1)
                done_cnt++;
        end
        checks++;
        if (done_cnt != 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d pulses want 2", done_cnt);
        end

        // Randomized streams against the micro-step queue model
        clr = 1'b1; run = 1'b0;
        @(posedge clk); #2;
        mq.delete(); m_halted = 0; m_ill = 0;
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            run = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
            if (clr) begin
                mq.delete(); m_halted = 0; m_ill = 0;
            end else if (mq.size() > 0) begin
                s = mq.pop_front();
                s_done = (s.o.stb & B_DONE) != 16'h0;
                if (s.halt_after) begin
                    m_halted = 1; m_ill = 1;
                end else if (s_done && run) begin
                    start_instr();
                end
            end else if (!m_halted && run) begin
                start_instr();
            end
            #1;
            exp = (mq.size() > 0) ? mq[0].o : mk(0, 0, 0, 0);
            check_out("rand", exp, m_ill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
